// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared constants and types for the clock-divider bank.
//   CNT_W_DEF   : default divisor/counter width
//   DEF_DIV_DEF : divisor loaded into every channel at reset
//                 (toggle every 2500 clk -> 10 kHz from 50 MHz)
//   ch_state_t  : one channel's architectural state
//   ch_w()      : channel-index width, never narrower than one bit
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned DEF_DIV_DEF = 2500;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] cnt;
      logic [CNT_W_DEF-1:0] div_act;
      logic [CNT_W_DEF-1:0] div_pend;
      logic                 pend_vld;
      logic [CNT_W_DEF-1:0] phase;
   } ch_state_t;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch
//   One divider channel: counter, 50%-duty toggle output, tick strobe and
//   pending-divisor handling so that a new divisor takes effect only at a
//   period boundary.
//   Optional feature macro: CLK_DIV_BANK_PHASE_EN (adds i_wr_phase and a
//   phase register loaded into the counter on sync).
// Ports
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_en       channel run enable
//   i_sync     global phase realign
//   i_wr_hit   accepted divisor write addressed to this channel
//   i_wr_div   new divisor
//   i_wr_phase new phase offset (CLK_DIV_BANK_PHASE_EN only)
//   o_clk_out  divided clock, period 2*D
//   o_tick     one-cycle strobe on every o_clk_out toggle
//   o_busy     a pending divisor is waiting for the period boundary
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr_hit,
   input  logic [CNT_W-1:0] i_wr_div,
`ifdef CLK_DIV_BANK_PHASE_EN
   input  logic [CNT_W-1:0] i_wr_phase,
`endif
   output logic             o_clk_out,
   output logic             o_tick,
   output logic             o_busy
);

   localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_act;
   logic [CNT_W-1:0] r_div_pend;
   logic             r_pend_vld;
   logic             r_clk_out;
   logic             r_tick;

   logic             w_run;
   logic             w_tc;
   logic [CNT_W-1:0] w_div_next;
   logic [CNT_W-1:0] w_cnt_sync;

   // A zero divisor parks the channel exactly like a cleared enable.
   assign w_run = i_en && (r_div_act != '0);
   assign w_tc  = w_run && (r_cnt == r_div_act - 1'b1);

   // Divisor that becomes active when one is loaded at this edge: a write in
   // the same cycle beats an older pending value.
   assign w_div_next = i_wr_hit   ? i_wr_div   :
                       r_pend_vld ? r_div_pend : r_div_act;

`ifdef CLK_DIV_BANK_PHASE_EN
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] w_phase_next;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= '0;
      end else if (i_wr_hit) begin
         r_phase <= i_wr_phase;
      end
   end

   // Phase is judged against the divisor that is active after this edge.
   assign w_phase_next = i_wr_hit ? i_wr_phase : r_phase;
   assign w_cnt_sync   = (w_phase_next < w_div_next) ? w_phase_next : '0;
`else
   assign w_cnt_sync   = '0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_div_act  <= DEF_DIV_L;
         r_div_pend <= '0;
         r_pend_vld <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else if (i_sync) begin
         r_cnt      <= w_cnt_sync;
         r_div_act  <= w_div_next;
         r_pend_vld <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else if (!w_run) begin
         // Idle: a write takes effect at once and restarts the count.
         r_tick <= 1'b0;
         if (i_wr_hit) begin
            r_div_act  <= i_wr_div;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
         end
      end else if (w_tc) begin
         r_cnt      <= '0;
         r_clk_out  <= ~r_clk_out;
         r_tick     <= 1'b1;
         r_div_act  <= w_div_next;
         r_pend_vld <= 1'b0;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= 1'b0;
         if (i_wr_hit) begin
            r_div_pend <= i_wr_div;
            r_pend_vld <= 1'b1;
         end
      end
   end

   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;
   assign o_busy    = r_pend_vld;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of NUM_CH independent, runtime-programmable clock dividers running
//   from the system clock, with a shared divisor write port and a global
//   sync that realigns every channel.
//   Optional feature macro: CLK_DIV_BANK_PHASE_EN (adds wr_phase; each
//   accepted write also sets that channel's sync phase offset).
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   ch_en    per-channel run enable
//   sync     one-cycle global phase realign
//   wr_en    divisor write strobe
//   wr_ch    target channel
//   wr_div   new divisor D
//   wr_phase new phase offset (CLK_DIV_BANK_PHASE_EN only)
//   wr_ack   pulse the cycle after an accepted write
//   wr_err   pulse the cycle after a write to a non-existent channel
//   clk_out  divided outputs, period 2*D clk
//   tick     one-cycle strobe coincident with each clk_out toggle
//   busy     channel holds a divisor not yet applied
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH  = 4,
   parameter  int unsigned CNT_W   = CNT_W_DEF,
   parameter  int unsigned DEF_DIV = DEF_DIV_DEF,
   localparam int unsigned CH_W    = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
`ifdef CLK_DIV_BANK_PHASE_EN
   input  logic [CNT_W-1:0]  wr_phase,
`endif
   output logic              wr_ack,
   output logic              wr_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   // One extra bit so the range check also works when NUM_CH is a power of two.
   localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

   logic              w_ch_ok;
   logic [NUM_CH-1:0] w_wr_hit;
   logic              r_wr_ack;
   logic              r_wr_err;

   assign w_ch_ok = ({1'b0, wr_ch} < NUM_CH_L);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ack <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_ack <= wr_en && w_ch_ok;
         r_wr_err <= wr_en && !w_ch_ok;
      end
   end

   assign wr_ack = r_wr_ack;
   assign wr_err = r_wr_err;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr_hit[g] = wr_en && w_ch_ok && (wr_ch == CH_W'(g));

      clk_div_ch #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .i_clk      (clk),
         .i_rst_n    (rst),
         .i_en       (ch_en[g]),
         .i_sync     (sync),
         .i_wr_hit   (w_wr_hit[g]),
         .i_wr_div   (wr_div),
`ifdef CLK_DIV_BANK_PHASE_EN
         .i_wr_phase (wr_phase),
`endif
         .o_clk_out  (clk_out[g]),
         .o_tick     (tick[g]),
         .o_busy     (busy[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
//   Directed scenarios followed by a randomized run. Every cycle the outputs
//   are compared with a reference model that tracks, per channel, how many
//   running cycles remain until the next toggle. A second, 3-channel instance
//   shares the write port so that out-of-range channel writes can be hit.
module tb_clk_div_bank;

   localparam int NCH  = 4;
   localparam int NCH1 = 3;
   localparam int DDIV = 2500;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ch_en = 4'hF;
   logic        sync = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_ch = 2'd0;
   logic [15:0] wr_div = 16'd0;
`ifdef CLK_DIV_BANK_PHASE_EN
   logic [15:0] wr_phase = 16'd0;
`endif
   logic        wr_ack, wr_err, wr_ack1, wr_err1;
   logic [3:0]  clk_out, tick, busy;
   logic [2:0]  clk_out1, tick1, busy1;

   always #5 clk = ~clk;

   clk_div_bank #(.NUM_CH(NCH), .CNT_W(16), .DEF_DIV(DDIV)) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLK_DIV_BANK_PHASE_EN
      .wr_phase(wr_phase),
`endif
      .wr_ack(wr_ack), .wr_err(wr_err), .clk_out(clk_out), .tick(tick), .busy(busy)
   );

   clk_div_bank #(.NUM_CH(NCH1), .CNT_W(16), .DEF_DIV(5)) dut1 (
      .clk(clk), .rst(rst), .ch_en(3'b000), .sync(sync), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLK_DIV_BANK_PHASE_EN
      .wr_phase(wr_phase),
`endif
      .wr_ack(wr_ack1), .wr_err(wr_err1), .clk_out(clk_out1), .tick(tick1), .busy(busy1)
   );

   // Reference model
   int unsigned m_div [NCH];
   int unsigned m_pend[NCH];
   int unsigned m_rem [NCH];
   int unsigned m_ph  [NCH];
   bit [3:0]    m_pv, m_out, m_tick;
   bit          m_ack, m_err, m_ack1, m_err1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_div[c] = DDIV; m_pend[c] = 0; m_rem[c] = DDIV; m_ph[c] = 0;
      end
      m_pv = '0; m_out = '0; m_tick = '0;
      m_ack = 0; m_err = 0; m_ack1 = 0; m_err1 = 0;
   endtask

   // Applies one clock edge of the rules using the inputs present at that edge.
   task automatic model_step();
      bit hit, run;
      int unsigned ph;
      m_ack  = wr_en && (int'(wr_ch) < NCH);
      m_err  = wr_en && !(int'(wr_ch) < NCH);
      m_ack1 = wr_en && (int'(wr_ch) < NCH1);
      m_err1 = wr_en && !(int'(wr_ch) < NCH1);
      for (int c = 0; c < NCH; c++) begin
         hit = m_ack && (int'(wr_ch) == c);
         ph  = m_ph[c];
`ifdef CLK_DIV_BANK_PHASE_EN
         if (hit) ph = wr_phase;
`endif
         m_ph[c]   = ph;
         m_tick[c] = 0;
         if (sync) begin
            if (hit) m_div[c] = wr_div;
            else if (m_pv[c]) m_div[c] = m_pend[c];
            m_pv[c]  = 0;
            m_out[c] = 0;
            m_rem[c] = (ph < m_div[c]) ? m_div[c] - ph : m_div[c];
         end else begin
            run = ch_en[c] && (m_div[c] != 0);
            if (!run) begin
               if (hit) begin
                  m_div[c] = wr_div; m_rem[c] = wr_div; m_pv[c] = 0;
               end
            end else if (m_rem[c] == 1) begin
               m_out[c]  = ~m_out[c];
               m_tick[c] = 1;
               if (hit) m_div[c] = wr_div;
               else if (m_pv[c]) m_div[c] = m_pend[c];
               m_pv[c]  = 0;
               m_rem[c] = m_div[c];
            end else begin
               m_rem[c]--;
               if (hit) begin
                  m_pend[c] = wr_div; m_pv[c] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("clk_out", clk_out, m_out);
      chk("tick",    tick,    m_tick);
      chk("busy",    busy,    m_pv);
      chk("wr_ack",  wr_ack,  m_ack);
      chk("wr_err",  wr_err,  m_err);
      chk("wr_ack1", wr_ack1, m_ack1);
      chk("wr_err1", wr_err1, m_err1);
      chk("idle1",   {clk_out1, tick1, busy1}, 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Steps until tick[ch] is seen; returns the step count, or 0 on timeout.
   task automatic steps_to_tick(input int ch, input int limit, output int n);
      n = 0;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (tick[ch] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wr(input int ch, input int d);
      wr_en = 1; wr_ch = 2'(ch); wr_div = 16'(d);
      step();
      wr_en = 0;
   endtask

   int n, t2, t3, exp_rem;

   initial begin
      model_reset();
      #2 rst = 0;
      #1 check_all();
      @(posedge clk); #1 rst = 1;

      // Default divisor after reset: first tick at 2500, half period 2500.
      steps_to_tick(0, 3000, n);
      chk("first_tick_cycle", n, 2500);
      steps_to_tick(0, 3000, n);
      chk("half_period", n, 2500);

      // Idle write of D=1 on ch1, then toggle every clock.
      ch_en[1] = 0; step();
      wr(1, 1);
      chk("ack_idle_wr", wr_ack, 1);
      ch_en[1] = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("d1_tick", tick[1], 1);
      end

      // ch0 at cnt=100: write D=10, pending until the old boundary.
      repeat (92) step();
      wr(0, 10);
      chk("busy_pending", busy[0], 1);
      steps_to_tick(0, 3000, n);
      chk("old_period_finish", n, 2399);
      chk("busy_cleared", busy[0], 0);
      steps_to_tick(0, 100, n);
      chk("new_half_period", n, 10);

      // Two writes before the boundary: last one wins.
      wr(0, 10);
      wr(0, 4);
      chk("busy_two_wr", busy[0], 1);
      steps_to_tick(0, 100, n);
      chk("two_wr_finish", n, 8);
      chk("busy_two_clr", busy[0], 0);
      steps_to_tick(0, 100, n);
      chk("last_wins_period", n, 4);

      // Out-of-range channel on the 3-channel instance.
      wr(3, 6);
      chk("err1_pulse", wr_err1, 1);
      chk("err1_no_ack", wr_ack1, 0);
      wr(2, 6);
      chk("ack1_pulse", wr_ack1, 1);

      // Sync realigns ch2 (D=7) and ch3 (D=3).
      wr(2, 7);
      wr(3, 3);
      sync = 1; step(); sync = 0;
      chk("sync_clk_out", clk_out[3:2], 0);
      t2 = 0; t3 = 0;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (tick[2] && t2 == 0) t2 = i;
         if (tick[3] && t3 == 0) t3 = i;
      end
      chk("sync_tick_ch2", t2, 7);
      chk("sync_tick_ch3", t3, 3);

      // Pause ch0 for 50 cycles mid-period.
      step(); step();
      ch_en[0] = 0;
      exp_rem = int'(m_rem[0]);
      for (int i = 0; i < 50; i++) begin
         step();
         chk("paused_tick", tick[0], 0);
      end
      ch_en[0] = 1;
      steps_to_tick(0, 100, n);
      chk("resume_remaining", n, exp_rem);

      // D=0 parks ch2 after its boundary.
      wr(2, 0);
      repeat (10) step();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("parked_tick", tick[2], 0);
      end

`ifdef CLK_DIV_BANK_PHASE_EN
      wr_phase = 16'd2;
      wr(3, 5);
      wr_phase = 16'd0;
      sync = 1; step(); sync = 0;
      steps_to_tick(3, 20, n);
      chk("phase_first_tick", n, 3);
`endif

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         wr_en  = ($urandom_range(0, 3) == 0);
         wr_ch  = 2'($urandom_range(0, 3));
         wr_div = 16'($urandom_range(0, 12));
`ifdef CLK_DIV_BANK_PHASE_EN
         wr_phase = 16'($urandom_range(0, 12));
`endif
         sync = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 15) == 0) begin
            int k;
            k = $urandom_range(0, 3);
            ch_en[k] = ~ch_en[k];
         end
         step();
      end
      wr_en = 0; sync = 0;

      // Asynchronous reset mid-period.
      repeat (3) step();
      @(posedge clk); #3 rst = 0;
      model_reset();
      #1 check_all();
      @(posedge clk); #1 rst = 1;
      ch_en = 4'hF;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
